// File: rtl/uart_tx_arbiter.sv
// Four-requester arbiter feeding a single UART transmitter, one byte per frame.
// Define UART_TX_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins); round-robin otherwise.
module uart_tx_arbiter #(
    parameter int CLKS_PER_FRAME = 104170,
    parameter int GAP_CLKS       = 0
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [3:0]  i_req,
    input  logic [31:0] i_data,
    output logic [3:0]  o_grant,
    output logic [3:0]  o_done,
    output logic        o_tx_start,
    output logic [7:0]  o_tx_data,
    output logic        o_busy,
    output logic [1:0]  o_owner
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOAD = 2'd1;
    localparam logic [1:0] SEND = 2'd2;
    localparam logic [1:0] GAP  = 2'd3;

    localparam int CNT_MAX = (CLKS_PER_FRAME > GAP_CLKS) ? CLKS_PER_FRAME : GAP_CLKS;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       grant_q, grant_d;
    logic [3:0]       done_q, done_d;
    logic             start_q, start_d;
    logic [7:0]       data_q, data_d;
    logic             busy_q, busy_d;
    logic [1:0]       owner_q, owner_d;
    logic [1:0]       win;

`ifdef UART_TX_ARB_FIXED_PRIO_EN
    always_comb begin
        win = 2'd0;
        for (int i = 3; i >= 0; i--)
            if (i_req[i]) win = 2'(i);
    end
`else
    logic [1:0] ptr_q, ptr_d;
    logic [1:0] idx;

    // Walk from the far end so the requester nearest the pointer is assigned last and wins.
    always_comb begin
        win = 2'd0;
        idx = ptr_q;
        for (int i = 3; i >= 0; i--) begin
            idx = ptr_q + 2'(i);
            if (i_req[idx]) win = idx;
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (state_q == IDLE && |i_req) ptr_d = win + 2'd1;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) ptr_q <= 2'd0;
        else         ptr_q <= ptr_d;
    end
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        grant_d = 4'd0;
        done_d  = 4'd0;
        start_d = 1'b0;
        data_d  = data_q;
        busy_d  = busy_q;
        owner_d = owner_q;
        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (|i_req) begin
                    state_d = LOAD;
                    owner_d = win;
                    data_d  = i_data[8*win +: 8];
                    grant_d = 4'b0001 << win;
                    start_d = 1'b1;
                    busy_d  = 1'b1;
                    cnt_d   = '0;
                end
            end
            LOAD: begin
                state_d = SEND;
                cnt_d   = CNT_W'(1);
            end
            SEND: begin
                // cnt counts cycles since LOAD; the frame ends on cycle CLKS_PER_FRAME-1.
                if (cnt_q == CNT_W'(CLKS_PER_FRAME - 1)) begin
                    done_d = 4'b0001 << owner_q;
                    cnt_d  = '0;
                    if (GAP_CLKS > 0) begin
                        state_d = GAP;
                    end else begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            GAP: begin
                if (cnt_q == CNT_W'(GAP_CLKS - 1)) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            grant_q <= 4'd0;
            done_q  <= 4'd0;
            start_q <= 1'b0;
            data_q  <= 8'h00;
            busy_q  <= 1'b0;
            owner_q <= 2'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            grant_q <= grant_d;
            done_q  <= done_d;
            start_q <= start_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
            owner_q <= owner_d;
        end
    end

    assign o_grant    = grant_q;
    assign o_done     = done_q;
    assign o_tx_start = start_q;
    assign o_tx_data  = data_q;
    assign o_busy     = busy_q;
    assign o_owner    = owner_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Random-stimulus bench: two arbiters (guard 0 and guard 5) share inputs and are
// compared every cycle against a frame-timeline model of grants, frames and guards.
module tb_uart_tx_arbiter;
    localparam int CPF = 20;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req = 4'd0;
    logic [31:0] data = 32'd0;

    logic [3:0] gnt   [2];
    logic [3:0] done  [2];
    logic       start [2];
    logic [7:0] txd   [2];
    logic       busy  [2];
    logic [1:0] own   [2];

    always #5 clk = ~clk;

    uart_tx_arbiter #(.CLKS_PER_FRAME(CPF), .GAP_CLKS(0)) u_g0 (
        .i_clk(clk), .i_reset(rst), .i_req(req), .i_data(data),
        .o_grant(gnt[0]), .o_done(done[0]), .o_tx_start(start[0]),
        .o_tx_data(txd[0]), .o_busy(busy[0]), .o_owner(own[0]));

    uart_tx_arbiter #(.CLKS_PER_FRAME(CPF), .GAP_CLKS(5)) u_g5 (
        .i_clk(clk), .i_reset(rst), .i_req(req), .i_data(data),
        .o_grant(gnt[1]), .o_done(done[1]), .o_tx_start(start[1]),
        .o_tx_data(txd[1]), .o_busy(busy[1]), .o_owner(own[1]));

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;
    bit skip = 1'b0;

    // Model: each DUT is described by the cycle of its latest grant plus what was granted.
    int         m_g   [2];
    logic [1:0] m_own [2];
    logic [1:0] m_ptr [2];
    logic [7:0] m_dat [2];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, act, exp);
        end
    endtask

    function automatic int gap_of(input int d);
        return (d == 1) ? 5 : 0;
    endfunction

    function automatic logic [1:0] pick(input logic [3:0] r, input logic [1:0] p);
`ifdef UART_TX_ARB_FIXED_PRIO_EN
        for (int k = 0; k < 4; k++)
            if (r[k]) return 2'(k);
        return p;
`else
        for (int k = 0; k < 4; k++) begin
            logic [1:0] cand;
            cand = 2'((int'(p) + k) % 4);
            if (r[cand]) return cand;
        end
        return p;
`endif
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_g[d]   = -1;
            m_own[d] = 2'd0;
            m_ptr[d] = 2'd0;
            m_dat[d] = 8'h00;
        end
    endtask

    // Arbitration at the edge that opened cycle cyc, if the previous cycle was idle.
    task automatic model_edge();
        for (int d = 0; d < 2; d++) begin
            bit idle;
            idle = (m_g[d] < 0) || (cyc - 1 >= m_g[d] + CPF + gap_of(d));
            if (idle && req != 4'd0) begin
                logic [1:0] w;
                w = pick(req, m_ptr[d]);
                m_g[d]   = cyc;
                m_own[d] = w;
                m_dat[d] = data[8*w +: 8];
                m_ptr[d] = w + 2'd1;
            end
        end
    endtask

    task automatic compare();
        for (int d = 0; d < 2; d++) begin
            bit         has;
            logic [3:0] oh;
            int         g;
            g   = m_g[d];
            has = (g >= 0);
            oh  = 4'b0001 << m_own[d];
            chk($sformatf("grant/gap%0d", gap_of(d)), 32'(gnt[d]),
                32'((has && cyc == g) ? oh : 4'd0));
            chk($sformatf("tx_start/gap%0d", gap_of(d)), 32'(start[d]),
                32'(has && cyc == g));
            chk($sformatf("done/gap%0d", gap_of(d)), 32'(done[d]),
                32'((has && cyc == g + CPF) ? oh : 4'd0));
            chk($sformatf("busy/gap%0d", gap_of(d)), 32'(busy[d]),
                32'(has && cyc >= g && cyc < g + CPF + gap_of(d)));
            chk($sformatf("tx_data/gap%0d", gap_of(d)), 32'(txd[d]), 32'(m_dat[d]));
            chk($sformatf("owner/gap%0d", gap_of(d)), 32'(own[d]), 32'(m_own[d]));
        end
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        @(negedge clk);
        if (!skip) model_edge();
        skip = 1'b0;
        compare();
        if (rst) rst = 1'b0;
    endtask

    task automatic mutate_inputs();
        for (int k = 0; k < 4; k++) begin
            if ($urandom_range(15) == 0) begin
                req[k] = ~req[k];
                if (req[k]) data[8*k +: 8] = 8'($urandom);
            end else if (!req[k] && $urandom_range(7) == 0) begin
                data[8*k +: 8] = 8'($urandom);
            end
        end
        // Asynchronous reset lands mid-cycle and must clear outputs without a clock edge.
        if ($urandom_range(299) == 0) begin
            rst = 1'b1;
            #1;
            model_reset();
            compare();
            skip = 1'b1;
        end
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        compare();
        @(posedge clk);
        cyc++;
        @(negedge clk);
        compare();
        req  = 4'hF;
        data = 32'h55484A4B;
        rst  = 1'b0;
        for (int i = 0; i < 200; i++) step();
        req = 4'h0;
        for (int i = 0; i < 40; i++) step();
        req  = 4'h1;
        data = 32'h0000004B;
        for (int i = 0; i < 10; i++) step();
        rst = 1'b1;
        #1;
        model_reset();
        compare();
        skip = 1'b1;
        req  = 4'h2;
        data = 32'h00006600;
        for (int i = 0; i < 5; i++) step();
        for (int i = 0; i < 3000; i++) begin
            step();
            mutate_inputs();
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter: CLKS_PER_FRAME, 104170, clock cycles one 10-bit frame occupies the transmitter (100 MHz / 9600 baud); legal minimum 2.
REQ-002 Parameter: GAP_CLKS, 0, idle guard cycles inserted after each frame; 0 = no guard.
REQ-003 Port: i_clk  input  1  single system clock; all logic on rising edge.
REQ-004 Port: i_reset  input  1  asynchronous, active-high reset.
REQ-005 Port: i_req  input  4  per-requester transmit request, bit k = requester k.
REQ-006 Port: i_data  input  32  requester bytes; requester k at bits [8k+7:8k].
REQ-007 Port: o_grant  output  4  one-hot, one-cycle pulse; byte of requester k accepted.
REQ-008 Port: o_done  output  4  one-hot, one-cycle pulse; frame of requester k finished.
REQ-009 Port: o_tx_start  output  1  start strobe to UART_TX i_start.
REQ-010 Port: o_tx_data  output  8  byte to UART_TX i_data_in.
REQ-011 Port: o_busy  output  1  transmitter owned by a requester.
REQ-012 Port: o_owner  output  2  index of current or last granted requester.

Function
REQ-013 FSM states SHALL be IDLE, LOAD, SEND, GAP; all outputs registered.
REQ-014 IDLE: at an edge with i_req != 0, SHALL pick winner, latch its byte into o_tx_data, set o_owner, enter LOAD.
REQ-015 LOAD (exactly 1 cycle): o_grant = winner one-hot, o_tx_start = 1, o_busy = 1; then SEND.
REQ-016 SEND: frame counter SHALL run so LOAD plus SEND last exactly CLKS_PER_FRAME cycles; o_tx_data held stable throughout.
REQ-017 o_done SHALL pulse for the owner in the first cycle after the last SEND cycle.
REQ-018 That cycle SHALL be GAP when GAP_CLKS > 0 (GAP lasts GAP_CLKS cycles, then IDLE), else IDLE.
REQ-019 o_busy SHALL be 1 from LOAD through the last GAP cycle, and 0 in IDLE.
REQ-020 o_tx_start SHALL be 0 in every state except LOAD.
REQ-021 Round-robin: after a grant to k, priority order SHALL be k+1, k+2, k+3, k (mod 4).
REQ-022 Request latency: i_req sampled in IDLE -> o_grant and o_tx_start in the next cycle.
REQ-023 Requests are level-sensitive and not queued; i_req while o_busy = 1 is ignored until IDLE.
REQ-024 A requester SHALL hold i_req and i_data until its grant; dropping i_req before grant withdraws the request.
REQ-025 A requester still asserting i_req in the cycle after its grant is a new request for its next byte.
REQ-026 With GAP_CLKS = 0, arbitration SHALL occur in the o_done cycle, so back-to-back frames start CLKS_PER_FRAME+1 cycles apart.
REQ-027 When all four requesters are active simultaneously, every requester SHALL be granted once per four frames.

Reset
REQ-028 Asserting i_reset at any time, including mid-frame, SHALL immediately force: state IDLE, o_grant 0, o_done 0, o_tx_start 0, o_tx_data 0x00, o_busy 0, o_owner 0, frame counter 0, round-robin pointer so requester 0 has highest priority.
REQ-029 An aborted frame SHALL produce no o_done pulse; after release, arbitration resumes on the first edge.

Configuration
REQ-030 Macro UART_TX_ARB_FIXED_PRIO_EN defined: fixed priority SHALL apply (lowest index wins) and the pointer is unused.
REQ-031 Macro UART_TX_ARB_FIXED_PRIO_EN undefined: round-robin per REQ-021 SHALL apply.

Verification (CLKS_PER_FRAME = 20, GAP_CLKS = 0 unless stated)
REQ-032 After reset, i_req = 0001, byte0 = 0x4B -> next cycle o_grant = 0001, o_tx_start = 1, o_tx_data = 0x4B; o_done = 0001 exactly 20 cycles after the grant.
REQ-033 i_req = 1111 held, bytes 0x4B/0x4A/0x48/0x55 -> grants 0001, 0010, 0100, 1000, 0001, spaced 21 cycles; with macro defined, grants are 0001 repeatedly.
REQ-034 Requester 2 asserts i_req mid-frame of requester 0 -> no grant until o_done = 0001, then o_grant = 0100 in the next cycle.
REQ-035 GAP_CLKS = 5, i_req = 0011 held -> o_busy stays 1 for 25 cycles per frame; second grant 26 cycles after the first.
REQ-036 i_reset pulsed 10 cycles into a frame -> o_busy, o_tx_start, o_grant = 0 immediately, no o_done; i_req = 0010 afterwards -> o_grant = 0010 next cycle.
